// File: rtl/sblk_row_dispatch_if.sv
// Input-side stream bundle for sblk_row_dispatch: the instruction stream and
// the activation stream, each with its routing fields and valid/ready pair.
interface sblk_row_dispatch_if #(
    parameter int WID_INST = 14,
    parameter int WID_ACT  = 16,
    parameter int WID_ROW  = 3
);
    logic [WID_INST-1:0]  inst_in_data;
    logic [WID_ROW-1:0]   inst_in_row;
    logic                 inst_in_bcast;
    logic                 inst_in_vld;
    logic                 inst_in_rdy;

    logic [2*WID_ACT-1:0] act_in_data;
    logic [WID_ROW-1:0]   act_in_row;
    logic                 act_in_bcast;
    logic                 act_in_vld;
    logic                 act_in_rdy;

    modport master (
        output inst_in_data, inst_in_row, inst_in_bcast, inst_in_vld,
        output act_in_data, act_in_row, act_in_bcast, act_in_vld,
        input  inst_in_rdy, act_in_rdy
    );

    modport slave (
        input  inst_in_data, inst_in_row, inst_in_bcast, inst_in_vld,
        input  act_in_data, act_in_row, act_in_bcast, act_in_vld,
        output inst_in_rdy, act_in_rdy
    );
endinterface

// File: rtl/sblk_row_dispatch.sv
// Front-end dispatcher for a row of superblocks: per-row instruction FIFOs
// feeding per-row issue FSMs, unicast/broadcast activation routing, and a
// registered psum readout mux with an aggregate idle flag.
module sblk_row_dispatch #(
    parameter int N_ROW           = 8,
    parameter int N_COLUMN        = 5,
    parameter int WID_ACT         = 16,
    parameter int WID_PSUM        = 32,
    parameter int WID_INST        = 14,
    parameter int INST_FIFO_DEPTH = 4,
    parameter int ACK_WAIT        = 4,
    parameter int WID_ROW         = (N_ROW > 1) ? $clog2(N_ROW) : 1
) (
    input  logic                                clk_h,
    input  logic                                rst,
    sblk_row_dispatch_if.slave                  stream,
    output logic [WID_INST*N_ROW-1:0]           inst_data,
    output logic [N_ROW-1:0]                    inst_en,
    output logic [2*WID_ACT*N_ROW-1:0]          act_data_in,
    output logic [N_ROW-1:0]                    act_data_in_vld,
    input  logic [N_ROW-1:0]                    act_data_in_req,
    input  logic [N_ROW-1:0]                    status_sblk,
    input  logic [2*WID_PSUM*N_COLUMN*N_ROW-1:0] psum_rd_data,
    input  logic [WID_ROW-1:0]                  psum_sel,
    output logic [2*WID_PSUM*N_COLUMN-1:0]      psum_out,
    output logic [N_ROW-1:0]                    fifo_full,
    output logic                                all_idle
);

    localparam int W_PS  = 2 * WID_PSUM * N_COLUMN;
    localparam int W_AB  = 2 * WID_ACT;
    localparam int PTR_W = $clog2(INST_FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ACK_W = (ACK_WAIT > 1) ? $clog2(ACK_WAIT) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUED = 2'd1,
        ST_BUSY   = 2'd2
    } row_state_t;

    logic                ready_r;
    logic                inst_rdy_s;
    logic                act_rdy_s;
    logic                inst_xfer_s;
    logic                act_xfer_s;
    logic                idle_nxt_s;
    logic [N_ROW-1:0]    inst_hit_s;
    logic [N_ROW-1:0]    act_hit_s;
    logic [N_ROW-1:0]    write_s;
    logic [N_ROW-1:0]    pop_s;
    logic [N_ROW-1:0]    room_s;
    logic [N_ROW-1:0]    act_tgt_s;
    logic [W_PS-1:0]     psum_mux_s;

    logic [WID_INST-1:0] mem_r       [N_ROW][INST_FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_r    [N_ROW];
    logic [PTR_W-1:0]    rd_ptr_r    [N_ROW];
    logic [CNT_W-1:0]    count_r     [N_ROW];
    logic [CNT_W-1:0]    count_nxt_s [N_ROW];
    row_state_t          state_r     [N_ROW];
    row_state_t          state_nxt_s [N_ROW];
    logic [ACK_W-1:0]    ack_cnt_r   [N_ROW];
    logic [ACK_W-1:0]    ack_cnt_nxt_s [N_ROW];

    // Ready gate: keeps both stream readies low in reset and the cycle after.
    always_ff @(posedge clk_h) begin
        if (rst) begin
            ready_r <= 1'b0;
        end else begin
            ready_r <= 1'b1;
        end
    end

    // Row-index decode for both streams; an out-of-range index hits no row.
    always_comb begin
        inst_hit_s = '0;
        act_hit_s  = '0;
        for (int r = 0; r < N_ROW; r++) begin
            inst_hit_s[r] = (stream.inst_in_row == WID_ROW'(r));
            act_hit_s[r]  = (stream.act_in_row == WID_ROW'(r));
        end
    end

    // FIFO room per row; a same-cycle pop frees the slot for the writer.
    always_comb begin
        room_s = '0;
        for (int r = 0; r < N_ROW; r++) begin
            room_s[r] = (count_r[r] != CNT_W'(INST_FIFO_DEPTH)) || pop_s[r];
        end
    end

    // Instruction handshake and per-row write enables; dropped rows are never written.
    always_comb begin
        if (!ready_r || rst) begin
            inst_rdy_s = 1'b0;
        end else if (stream.inst_in_bcast) begin
            inst_rdy_s = &room_s;
        end else if (|inst_hit_s) begin
            inst_rdy_s = |(inst_hit_s & room_s);
        end else begin
            inst_rdy_s = 1'b1;
        end
        inst_xfer_s = stream.inst_in_vld && inst_rdy_s;
        if (!inst_xfer_s) begin
            write_s = '0;
        end else if (stream.inst_in_bcast) begin
            write_s = '1;
        end else begin
            write_s = inst_hit_s;
        end
    end

    assign stream.inst_in_rdy = inst_rdy_s;

    // Activation handshake and target mask; broadcast waits for every row's request.
    always_comb begin
        if (!ready_r || rst) begin
            act_rdy_s = 1'b0;
        end else if (stream.act_in_bcast) begin
            act_rdy_s = &act_data_in_req;
        end else if (|act_hit_s) begin
            act_rdy_s = |(act_hit_s & act_data_in_req);
        end else begin
            act_rdy_s = 1'b1;
        end
        act_xfer_s = stream.act_in_vld && act_rdy_s;
        if (!act_xfer_s) begin
            act_tgt_s = '0;
        end else if (stream.act_in_bcast) begin
            act_tgt_s = '1;
        end else begin
            act_tgt_s = act_hit_s;
        end
    end

    assign stream.act_in_rdy = act_rdy_s;

    // FIFO storage writes; contents need no reset since pointers gate every read.
    always_ff @(posedge clk_h) begin
        for (int r = 0; r < N_ROW; r++) begin
            if (write_s[r]) begin
                mem_r[r][wr_ptr_r[r]] <= stream.inst_in_data;
            end
        end
    end

    // Next occupancy per row from the write and pop of this cycle.
    always_comb begin
        for (int r = 0; r < N_ROW; r++) begin
            count_nxt_s[r] = count_r[r];
            case ({write_s[r], pop_s[r]})
                2'b10:   count_nxt_s[r] = count_r[r] + CNT_W'(1);
                2'b01:   count_nxt_s[r] = count_r[r] - CNT_W'(1);
                default: count_nxt_s[r] = count_r[r];
            endcase
        end
    end

    // FIFO pointers and occupancy; reset discards anything queued.
    always_ff @(posedge clk_h) begin
        if (rst) begin
            for (int r = 0; r < N_ROW; r++) begin
                wr_ptr_r[r] <= '0;
                rd_ptr_r[r] <= '0;
                count_r[r]  <= '0;
            end
        end else begin
            for (int r = 0; r < N_ROW; r++) begin
                if (write_s[r]) begin
                    wr_ptr_r[r] <= wr_ptr_r[r] + PTR_W'(1);
                end
                if (pop_s[r]) begin
                    rd_ptr_r[r] <= rd_ptr_r[r] + PTR_W'(1);
                end
                count_r[r] <= count_nxt_s[r];
            end
        end
    end

    // Row FSM state register with its acknowledge-timeout counter.
    always_ff @(posedge clk_h) begin
        if (rst) begin
            for (int r = 0; r < N_ROW; r++) begin
                state_r[r]   <= ST_IDLE;
                ack_cnt_r[r] <= '0;
            end
        end else begin
            for (int r = 0; r < N_ROW; r++) begin
                state_r[r]   <= state_nxt_s[r];
                ack_cnt_r[r] <= ack_cnt_nxt_s[r];
            end
        end
    end

    // Row FSM next state: a row that never drops status is released after ACK_WAIT cycles.
    always_comb begin
        for (int r = 0; r < N_ROW; r++) begin
            state_nxt_s[r]   = state_r[r];
            ack_cnt_nxt_s[r] = ack_cnt_r[r];
            case (state_r[r])
                ST_IDLE: begin
                    if (pop_s[r]) begin
                        state_nxt_s[r]   = ST_ISSUED;
                        ack_cnt_nxt_s[r] = '0;
                    end else begin
                        state_nxt_s[r]   = ST_IDLE;
                    end
                end
                ST_ISSUED: begin
                    if (!status_sblk[r]) begin
                        state_nxt_s[r] = ST_BUSY;
                    end else if (ack_cnt_r[r] == ACK_W'(ACK_WAIT - 1)) begin
                        state_nxt_s[r] = ST_IDLE;
                    end else begin
                        ack_cnt_nxt_s[r] = ack_cnt_r[r] + ACK_W'(1);
                    end
                end
                ST_BUSY: begin
                    if (status_sblk[r]) begin
                        state_nxt_s[r] = ST_IDLE;
                    end else begin
                        state_nxt_s[r] = ST_BUSY;
                    end
                end
                default: begin
                    state_nxt_s[r]   = ST_IDLE;
                    ack_cnt_nxt_s[r] = '0;
                end
            endcase
        end
    end

    // Row FSM outputs: pop the head when the row is idle, queued and the superblock is idle.
    always_comb begin
        pop_s = '0;
        for (int r = 0; r < N_ROW; r++) begin
            pop_s[r] = (state_r[r] == ST_IDLE) && (count_r[r] != '0) && status_sblk[r];
        end
    end

    // Registered issue strobe and instruction word; the word holds after the strobe.
    always_ff @(posedge clk_h) begin
        if (rst) begin
            inst_en   <= '0;
            inst_data <= '0;
        end else begin
            for (int r = 0; r < N_ROW; r++) begin
                inst_en[r] <= pop_s[r];
                if (pop_s[r]) begin
                    inst_data[r*WID_INST +: WID_INST] <= mem_r[r][rd_ptr_r[r]];
                end
            end
        end
    end

    // Registered activation delivery, one-cycle valid to the targeted rows only.
    always_ff @(posedge clk_h) begin
        if (rst) begin
            act_data_in_vld <= '0;
            act_data_in     <= '0;
        end else begin
            act_data_in_vld <= act_tgt_s;
            for (int r = 0; r < N_ROW; r++) begin
                if (act_tgt_s[r]) begin
                    act_data_in[r*W_AB +: W_AB] <= stream.act_in_data;
                end
            end
        end
    end

    // Psum readout mux; an out-of-range select yields zero.
    always_comb begin
        psum_mux_s = '0;
        for (int r = 0; r < N_ROW; r++) begin
            if (psum_sel == WID_ROW'(r)) begin
                psum_mux_s = psum_rd_data[r*W_PS +: W_PS];
            end
        end
    end

    // Aggregate idle from post-edge queue/FSM state and current superblock status.
    always_comb begin
        idle_nxt_s = &status_sblk;
        for (int r = 0; r < N_ROW; r++) begin
            if ((count_nxt_s[r] != '0) || (state_nxt_s[r] != ST_IDLE)) begin
                idle_nxt_s = 1'b0;
            end
        end
    end

    // Registered psum readout, full flags and idle flag.
    always_ff @(posedge clk_h) begin
        if (rst) begin
            psum_out  <= '0;
            fifo_full <= '0;
            all_idle  <= 1'b0;
        end else begin
            psum_out <= psum_mux_s;
            for (int r = 0; r < N_ROW; r++) begin
                fifo_full[r] <= (count_nxt_s[r] == CNT_W'(INST_FIFO_DEPTH));
            end
            all_idle <= idle_nxt_s;
        end
    end

endmodule

// File: tb/tb_sblk_row_dispatch.sv
// Directed self-checking bench for sblk_row_dispatch (N_ROW=8, WID_ROW=4 so
// out-of-range row indices can be driven).
module tb_sblk_row_dispatch;

    localparam int N_ROW = 8;
    localparam int WROW  = 4;
    localparam int W_PS  = 320;

    logic                   clk_h = 1'b0;
    logic                   rst;
    logic [112-1:0]         inst_data;
    logic [N_ROW-1:0]       inst_en;
    logic [256-1:0]         act_data_in;
    logic [N_ROW-1:0]       act_data_in_vld;
    logic [N_ROW-1:0]       act_data_in_req;
    logic [N_ROW-1:0]       status_sblk;
    logic [W_PS*N_ROW-1:0]  psum_rd_data;
    logic [WROW-1:0]        psum_sel;
    logic [W_PS-1:0]        psum_out;
    logic [N_ROW-1:0]       fifo_full;
    logic                   all_idle;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    sblk_row_dispatch_if #(.WID_INST(14), .WID_ACT(16), .WID_ROW(WROW)) bus ();

    sblk_row_dispatch #(.WID_ROW(WROW)) dut (
        .clk_h           (clk_h),
        .rst             (rst),
        .stream          (bus),
        .inst_data       (inst_data),
        .inst_en         (inst_en),
        .act_data_in     (act_data_in),
        .act_data_in_vld (act_data_in_vld),
        .act_data_in_req (act_data_in_req),
        .status_sblk     (status_sblk),
        .psum_rd_data    (psum_rd_data),
        .psum_sel        (psum_sel),
        .psum_out        (psum_out),
        .fifo_full       (fifo_full),
        .all_idle        (all_idle)
    );

    always #5 clk_h = ~clk_h;

    task automatic cyc();
        @(posedge clk_h);
        #1;
    endtask

    task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        chk(tag, 320'(obs), 320'(exp));
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        chk(tag, 320'(obs), 320'(exp));
    endtask

    function automatic logic [319:0] pat(input int r);
        logic [319:0] v;
        for (int c = 0; c < 10; c++) begin
            v[c*32 +: 32] = 32'hA500_0000 + 32'(r * 256 + c);
        end
        return v;
    endfunction

    initial begin
        logic [13:0] w;
        rst = 1'b1;
        bus.inst_in_data = 14'h0; bus.inst_in_row = 4'd0; bus.inst_in_bcast = 1'b0; bus.inst_in_vld = 1'b0;
        bus.act_in_data = 32'h0; bus.act_in_row = 4'd0; bus.act_in_bcast = 1'b0; bus.act_in_vld = 1'b0;
        status_sblk = 8'hFF;
        act_data_in_req = 8'hFF;
        psum_sel = 4'd0;
        for (int r = 0; r < N_ROW; r++) psum_rd_data[r*W_PS +: W_PS] = pat(r);

        // Reset state
        cyc(); cyc(); #2;
        chk8("rst_inst_en", inst_en, 8'h00);
        chk("rst_inst_data", 320'(inst_data), 320'd0);
        chk8("rst_act_vld", act_data_in_vld, 8'h00);
        chk("rst_act_data", 320'(act_data_in), 320'd0);
        chk("rst_psum", psum_out, 320'd0);
        chk8("rst_fifo_full", fifo_full, 8'h00);
        chk1("rst_all_idle", all_idle, 1'b0);
        chk1("rst_inst_rdy", bus.inst_in_rdy, 1'b0);
        chk1("rst_act_rdy", bus.act_in_rdy, 1'b0);
        rst = 1'b0; #2;
        chk1("first_inst_rdy", bus.inst_in_rdy, 1'b0);
        chk1("first_act_rdy", bus.act_in_rdy, 1'b0);
        chk1("first_all_idle", all_idle, 1'b0);
        cyc(); #2;
        chk1("post_inst_rdy", bus.inst_in_rdy, 1'b1);
        chk1("post_act_rdy", bus.act_in_rdy, 1'b1);
        chk1("post_all_idle", all_idle, 1'b1);

        // Unicast instruction to row 2; issue two cycles after acceptance
        bus.inst_in_data = 14'h1234; bus.inst_in_row = 4'd2; bus.inst_in_bcast = 1'b0; bus.inst_in_vld = 1'b1; #2;
        chk1("uni_rdy", bus.inst_in_rdy, 1'b1);
        cyc(); bus.inst_in_vld = 1'b0; #2;
        chk8("uni_en_early", inst_en, 8'h00);
        chk1("uni_not_idle", all_idle, 1'b0);
        cyc(); #2;
        chk8("uni_en", inst_en, 8'h04);
        chk("uni_data", 320'(inst_data[2*14 +: 14]), 320'(14'h1234));
        status_sblk = 8'hFB;
        for (int i = 0; i < 5; i++) begin
            cyc(); #2;
            chk8("busy_no_issue", inst_en, 8'h00);
            chk1("busy_not_idle", all_idle, 1'b0);
        end
        status_sblk = 8'hFF;
        cyc(); #2;
        chk1("busy_done_idle", all_idle, 1'b1);
        cyc(); cyc(); #2;
        chk8("no_second_issue", inst_en, 8'h00);

        // Broadcast four words while every row is busy
        status_sblk = 8'h00;
        for (int k = 0; k < 4; k++) begin
            bus.inst_in_data = 14'h0100 + 14'(k); bus.inst_in_bcast = 1'b1; bus.inst_in_vld = 1'b1; #2;
            chk1("bc_fill_rdy", bus.inst_in_rdy, 1'b1);
            cyc();
        end
        bus.inst_in_data = 14'h0104; #2;
        chk1("bc_full_rdy", bus.inst_in_rdy, 1'b0);
        chk8("bc_fifo_full", fifo_full, 8'hFF);
        cyc(); #2;
        chk1("bc_stall_rdy", bus.inst_in_rdy, 1'b0);
        chk8("bc_stall_en", inst_en, 8'h00);
        status_sblk = 8'hFF; #2;
        chk1("bc_pop_frees_rdy", bus.inst_in_rdy, 1'b1);
        cyc(); bus.inst_in_vld = 1'b0; bus.inst_in_bcast = 1'b0; #2;
        chk8("bc_en0", inst_en, 8'hFF);
        chk("bc_data0", 320'(inst_data), 320'({8{14'h0100}}));
        chk8("bc_full_after_pop_push", fifo_full, 8'hFF);
        // Status held high: each issue is followed by ACK_WAIT cycles in ISSUED, one IDLE cycle, then the next strobe
        for (int k = 1; k < 5; k++) begin
            for (int j = 0; j < 4; j++) begin
                cyc(); #2;
                chk8("ack_gap_en", inst_en, 8'h00);
            end
            cyc(); #2;
            w = 14'h0100 + 14'(k);
            chk8("ack_next_en", inst_en, 8'hFF);
            chk("ack_next_data", 320'(inst_data), 320'({8{w}}));
            chk8("ack_next_full", fifo_full, 8'h00);
        end
        cyc(); #2;
        chk8("hold_en", inst_en, 8'h00);
        chk("hold_data", 320'(inst_data), 320'({8{14'h0104}}));
        cyc(); cyc(); cyc(); #2;
        chk1("bc_drained_idle", all_idle, 1'b1);

        // Out-of-range unicast instruction is accepted and dropped
        bus.inst_in_data = 14'h3FFF; bus.inst_in_row = 4'd9; bus.inst_in_vld = 1'b1; #2;
        chk1("oor_inst_rdy", bus.inst_in_rdy, 1'b1);
        cyc(); bus.inst_in_vld = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc(); #2;
            chk8("oor_inst_no_en", inst_en, 8'h00);
        end
        chk1("oor_inst_idle", all_idle, 1'b1);

        // Activation routing
        bus.act_in_data = 32'hBEEF_0001; bus.act_in_bcast = 1'b1; bus.act_in_vld = 1'b1; #2;
        chk1("act_bc_rdy", bus.act_in_rdy, 1'b1);
        cyc(); #2;
        chk8("act_bc_vld", act_data_in_vld, 8'hFF);
        chk("act_bc_data", 320'(act_data_in), 320'({8{32'hBEEF_0001}}));
        act_data_in_req = 8'h7F; bus.act_in_data = 32'h1234_5678; #2;
        chk1("act_bc_stall", bus.act_in_rdy, 1'b0);
        cyc(); #2;
        chk8("act_vld_one_cycle", act_data_in_vld, 8'h00);
        chk1("act_bc_still_stall", bus.act_in_rdy, 1'b0);
        bus.act_in_bcast = 1'b0; bus.act_in_row = 4'd3; bus.act_in_data = 32'hCAFE_0003; #2;
        chk1("act_uni3_rdy", bus.act_in_rdy, 1'b1);
        cyc(); #2;
        chk8("act_uni3_vld", act_data_in_vld, 8'h08);
        chk("act_uni3_data", 320'(act_data_in[3*32 +: 32]), 320'(32'hCAFE_0003));
        chk("act_row0_hold", 320'(act_data_in[0 +: 32]), 320'(32'hBEEF_0001));
        bus.act_in_bcast = 1'b1; bus.act_in_data = 32'h1234_5678; act_data_in_req = 8'hFF; #2;
        chk1("act_bc2_rdy", bus.act_in_rdy, 1'b1);
        cyc(); #2;
        chk8("act_bc2_vld", act_data_in_vld, 8'hFF);
        chk("act_bc2_data", 320'(act_data_in), 320'({8{32'h1234_5678}}));
        bus.act_in_bcast = 1'b0; bus.act_in_row = 4'd12; bus.act_in_data = 32'hDEAD_0000; act_data_in_req = 8'h00; #2;
        chk1("act_oor_rdy", bus.act_in_rdy, 1'b1);
        bus.act_in_row = 4'd6; #2;
        chk1("act_uni6_noreq", bus.act_in_rdy, 1'b0);
        bus.act_in_row = 4'd12;
        cyc(); #2;
        chk8("act_oor_vld", act_data_in_vld, 8'h00);
        chk("act_oor_data", 320'(act_data_in), 320'({8{32'h1234_5678}}));
        act_data_in_req = 8'hFF; bus.act_in_row = 4'd0; bus.act_in_data = 32'h0000_00A0;
        cyc(); #2;
        chk8("act_b2b_vld0", act_data_in_vld, 8'h01);
        bus.act_in_row = 4'd7; bus.act_in_data = 32'h0000_00A7;
        cyc(); #2;
        chk8("act_b2b_vld7", act_data_in_vld, 8'h80);
        chk("act_b2b_data7", 320'(act_data_in[7*32 +: 32]), 320'(32'h0000_00A7));
        chk("act_b2b_data0", 320'(act_data_in[0 +: 32]), 320'(32'h0000_00A0));
        bus.act_in_vld = 1'b0;
        cyc(); #2;
        chk8("act_idle_vld", act_data_in_vld, 8'h00);

        // Psum readout
        for (int r = 0; r < N_ROW; r++) begin
            psum_sel = 4'(r);
            cyc(); #2;
            chk("psum_row", psum_out, pat(r));
        end
        psum_sel = 4'd3; #2;
        chk("psum_latency", psum_out, pat(7));
        cyc(); #2;
        chk("psum_row3", psum_out, pat(3));
        psum_sel = 4'd8;
        cyc(); #2;
        chk("psum_oor8", psum_out, 320'd0);
        psum_sel = 4'd2;
        cyc(); #2;
        chk("psum_row2", psum_out, pat(2));

        // Fill row 5, then reset mid-issue
        status_sblk = 8'hDF;
        for (int k = 0; k < 4; k++) begin
            bus.inst_in_data = 14'h0500 + 14'(k); bus.inst_in_row = 4'd5; bus.inst_in_bcast = 1'b0; bus.inst_in_vld = 1'b1; #2;
            chk1("r5_fill_rdy", bus.inst_in_rdy, 1'b1);
            cyc();
        end
        bus.inst_in_data = 14'h0504; #2;
        chk1("r5_full_rdy", bus.inst_in_rdy, 1'b0);
        chk8("r5_fifo_full", fifo_full, 8'h20);
        bus.inst_in_row = 4'd1; #2;
        chk1("r1_rdy_indep", bus.inst_in_rdy, 1'b1);
        bus.inst_in_vld = 1'b0;
        status_sblk = 8'hFF;
        cyc(); #2;
        chk8("r5_issue_en", inst_en, 8'h20);
        chk("r5_issue_data", 320'(inst_data[5*14 +: 14]), 320'(14'h0500));
        rst = 1'b1; #2;
        chk1("mid_rst_rdy", bus.inst_in_rdy, 1'b0);
        cyc(); #2;
        chk8("mid_rst_en", inst_en, 8'h00);
        chk("mid_rst_data", 320'(inst_data), 320'd0);
        chk8("mid_rst_full", fifo_full, 8'h00);
        chk1("mid_rst_idle", all_idle, 1'b0);
        chk("mid_rst_act", 320'(act_data_in), 320'd0);
        chk("mid_rst_psum", psum_out, 320'd0);
        rst = 1'b0; #2;
        chk1("rel_first_rdy", bus.inst_in_rdy, 1'b0);
        cyc(); #2;
        chk1("rel_idle", all_idle, 1'b1);
        chk1("rel_rdy", bus.inst_in_rdy, 1'b1);
        for (int i = 0; i < 6; i++) begin
            cyc(); #2;
            chk8("rel_no_stale_en", inst_en, 8'h00);
        end
        chk1("rel_still_idle", all_idle, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
